// File: rtl/csd_conv_arbiter_if.sv
// Handshake bundle between requesters, the shared CSD converter and the arbiter.
// slave  : arbiter side (drives ack/result/converter launch)
// master : client + converter side
interface csd_conv_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] operand;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      res_pos;
    logic [DW-1:0]      res_neg;
    logic               res_err;
    logic               busy;
    logic [IW-1:0]      grant_id;
    logic               conv_start;
    logic [DW-1:0]      conv_operand;
    logic               conv_done;
    logic [DW-1:0]      conv_pos;
    logic [DW-1:0]      conv_neg;

    modport slave (
        input  req, operand, conv_done, conv_pos, conv_neg,
        output ack, res_pos, res_neg, res_err, busy, grant_id,
               conv_start, conv_operand
    );

    modport master (
        output req, operand, conv_done, conv_pos, conv_neg,
        input  ack, res_pos, res_neg, res_err, busy, grant_id,
               conv_start, conv_operand
    );
endinterface

// File: rtl/csd_conv_arbiter.sv
// Round-robin arbiter sharing one CSD conversion datapath between NREQ clients.
// Flow per job: IDLE (pick + latch operand) -> ISSUE (hold start until done)
//               -> CAPTURE -> RESP (one-cycle ack to the winner) -> IDLE.
// Optional build macro CSD_ARB_TIMEOUT_EN adds a TMO-cycle watchdog on ISSUE
// that aborts the job with res_err=1; without it res_err is tied low.
module csd_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int TMO  = 64
) (
    input  logic               clk,
    input  logic               reset,
    csd_conv_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

    state_t          state, nxt;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   grant_id;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] sel_oh;
    logic [NREQ-1:0] pend;
    logic [IW-1:0]   win;
    logic            hit;
    logic [DW-1:0]   conv_operand;
    logic [DW-1:0]   res_pos, res_neg;
    logic            tmo_hit;

`ifdef CSD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO) + 1;
    logic [CW-1:0] cnt;
    logic          res_err;

    // Watchdog: counts ISSUE cycles, zero everywhere else so each job starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt <= '0;
        else if (state == S_ISSUE) cnt <= cnt + 1'b1;
        else                      cnt <= '0;
    end

    assign tmo_hit = (cnt == CW'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Round-robin pick: first pending bit at or above rr, else lowest pending bit
    always_comb begin
        pend = bus.req & ~mask;
        win  = '0;
        hit  = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!hit && pend[j] && (j >= int'(rr))) begin
                hit = 1'b1;
                win = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!hit && pend[j]) begin
                hit = 1'b1;
                win = IW'(j);
            end
        end
    end

    // One-hot of the current winner, shared by ack and the post-serve mask
    always_comb begin
        sel_oh = '0;
        sel_oh[grant_id] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // Next-state: done has priority over a same-cycle watchdog expiry
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (hit) nxt = S_ISSUE;
            S_ISSUE: begin
                if (bus.conv_done) nxt = S_CAPTURE;
                else if (tmo_hit)  nxt = S_RESP;
            end
            S_CAPTURE: nxt = S_RESP;
            S_RESP:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Job datapath: grant latch, result capture, mask and result clear on exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr           <= '0;
            grant_id     <= '0;
            mask         <= '0;
            conv_operand <= '0;
            res_pos      <= '0;
            res_neg      <= '0;
`ifdef CSD_ARB_TIMEOUT_EN
            res_err      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    mask <= '0;
                    if (hit) begin
                        grant_id     <= win;
                        rr           <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                        conv_operand <= bus.operand[win*DW +: DW];
                    end
                end
                S_ISSUE: begin
                    // conv_pos/neg are only valid alongside done, so grab them now
                    if (bus.conv_done) begin
                        res_pos <= bus.conv_pos;
                        res_neg <= bus.conv_neg;
                    end
`ifdef CSD_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        res_pos <= '0;
                        res_neg <= '0;
                        res_err <= 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    mask    <= sel_oh;
                    res_pos <= '0;
                    res_neg <= '0;
`ifdef CSD_ARB_TIMEOUT_EN
                    res_err <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.conv_start   = (state == S_ISSUE);
    assign bus.ack          = (state == S_RESP) ? sel_oh : '0;
    assign bus.grant_id     = grant_id;
    assign bus.conv_operand = conv_operand;
    assign bus.res_pos      = res_pos;
    assign bus.res_neg      = res_neg;
`ifdef CSD_ARB_TIMEOUT_EN
    assign bus.res_err      = res_err;
`else
    assign bus.res_err      = 1'b0;
`endif
endmodule

// File: tb/tb_csd_conv_arbiter.sv
// Bench for csd_conv_arbiter: directed scenarios plus a randomized traffic phase.
// A converter model (6-cycle latency, NAF/CSD by arithmetic) answers start
// pulses; a monitor predicts every grant and ack from round-robin rules.
// Build with CSD_ARB_TIMEOUT_EN to also exercise the watchdog (TMO=16).
module tb_csd_conv_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csd_conv_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    csd_conv_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cyc = -100;
    logic [3:0]  req_s;
    logic [31:0] op_s;
    bit          hang = 1'b0;
    bit          poke_done = 1'b0;
    int          ref_rr = 0;
    int          exp_id = -1;
    logic [7:0]  exp_op = '0;
    bit          busy_prev = 1'b0;
    int          ack_cnt [4] = '{0, 0, 0, 0};
    logic [7:0]  cnt_m;
    logic        st_prev;

    // Canonical signed-digit (non-adjacent form) of v, returned as {pos, neg}
    function automatic logic [15:0] csd(input int v);
        int x = v;
        int d;
        logic [7:0] p = '0;
        logic [7:0] n = '0;
        for (int b = 0; b < 8; b++) begin
            if (x % 2 != 0) begin
                d = 2 - (x % 4);
                if (d == 1) p[b] = 1'b1;
                else        n[b] = 1'b1;
                x = x - d;
            end
            x = x / 2;
        end
        return {p, n};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Converter model: launches on the rising edge of start, done 6 cycles later
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.conv_done <= 1'b0;
            bus.conv_pos  <= '0;
            bus.conv_neg  <= '0;
            cnt_m         <= '0;
            st_prev       <= 1'b0;
        end else begin
            st_prev       <= bus.conv_start;
            bus.conv_done <= poke_done;
            bus.conv_pos  <= 8'($urandom);
            bus.conv_neg  <= 8'($urandom);
            if (bus.conv_start && !st_prev && !hang) begin
                cnt_m <= 8'd6;
            end else if (cnt_m != 0) begin
                cnt_m <= cnt_m - 1'b1;
                if (cnt_m == 1) begin
                    bus.conv_done <= 1'b1;
                    {bus.conv_pos, bus.conv_neg} <= csd(int'(bus.conv_operand));
                end
            end
        end
    end

    // Snapshot what the DUT sees at each active edge
    always @(posedge clk) begin
        cyc++;
        req_s = bus.req;
        op_s  = bus.operand;
        if (bus.conv_done === 1'b1) done_cyc = cyc;
    end

    // Monitor: predict each grant and check each ack against it
    always @(negedge clk) begin
        if (reset) begin
            ref_rr    = 0;
            busy_prev = 1'b0;
        end else begin
            if (bus.busy && !busy_prev) begin
                exp_id = rr_pick(req_s, ref_rr);
                check("grant_id", 32'(bus.grant_id), exp_id);
                if (exp_id >= 0) begin
                    exp_op = op_s[exp_id*8 +: 8];
                    ref_rr = (exp_id + 1) % 4;
                end
                check("conv_operand", 32'(bus.conv_operand), 32'(exp_op));
            end
            if (bus.ack != 0) begin
                check("ack_onehot", 32'(bus.ack), (exp_id < 0) ? 0 : (1 << exp_id));
                if (hang) begin
                    check("res_err_tmo", 32'(bus.res_err), 1);
                    check("res_pn_tmo", {bus.res_pos, bus.res_neg}, 0);
                end else begin
                    check("res_err", 32'(bus.res_err), 0);
                    check("res_pn", {bus.res_pos, bus.res_neg}, 32'(csd(int'(exp_op))));
                    check("done_to_ack", cyc - done_cyc, 1);
                end
                for (int i = 0; i < 4; i++) ack_cnt[i] += int'(bus.ack[i]);
            end
            busy_prev = bus.busy;
        end
    end

    task automatic wait_ack(output logic [3:0] a);
        bit got = 1'b0;
        a = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                a   = bus.ack;
                got = 1'b1;
            end
        end
        check("ack_seen", 32'(got), 1);
    endtask

    task automatic wait_start();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.conv_start) got = 1'b1;
        end
        check("start_seen", 32'(got), 1);
    endtask

    logic [3:0] a;
    int         cool [4];
    int         base;
    int         n;
    bit         idle;

    initial begin
        bus.req     = '0;
        bus.operand = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_ack",    32'(bus.ack), 0);
        check("rst_start",  32'(bus.conv_start), 0);
        check("rst_res",    {bus.res_pos, bus.res_neg}, 0);
        check("rst_err",    32'(bus.res_err), 0);
        check("rst_gid",    32'(bus.grant_id), 0);
        check("rst_convop", 32'(bus.conv_operand), 0);
        reset = 1'b0;

        // Single request, operand 0x37
        @(negedge clk);
        bus.operand[7:0] = 8'h37;
        bus.req = 4'b0001;
        @(negedge clk);
        check("t1_start_lat", 32'(bus.conv_start), 1);
        check("t1_busy", 32'(bus.busy), 1);
        wait_ack(a);
        bus.req = '0;
        check("t1_ack", 32'(a), 32'h1);
        check("t1_pos", 32'(bus.res_pos), 32'h40);
        check("t1_neg", 32'(bus.res_neg), 32'h09);
        check("t1_start_off", 32'(bus.conv_start), 0);

        // Requests 1011 held from reset: order 0,1,3,0
        reset = 1'b1;
        bus.operand = 32'h44_33_22_11;
        bus.req = 4'b1011;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ack(a); check("t2_g0", 32'(a), 32'h1);
        wait_ack(a); check("t2_g1", 32'(a), 32'h2);
        wait_ack(a); check("t2_g2", 32'(a), 32'h8);
        wait_ack(a); check("t2_g3", 32'(a), 32'h1);
        bus.req = '0;

        // Operand boundaries 0x00 and 0x0F
        repeat (2) @(negedge clk);
        bus.operand[15:8] = 8'h00;
        bus.req = 4'b0010;
        wait_ack(a);
        bus.req = '0;
        check("t3_zero", {bus.res_pos, bus.res_neg}, 0);
        repeat (2) @(negedge clk);
        bus.operand[15:8] = 8'h0F;
        bus.req = 4'b0010;
        wait_ack(a);
        bus.req = '0;
        check("t3_0f_pos", 32'(bus.res_pos), 32'h10);
        check("t3_0f_neg", 32'(bus.res_neg), 32'h01);

        // Reset 3 cycles into ISSUE, then requester 2 alone
        repeat (2) @(negedge clk);
        bus.operand[7:0] = 8'h23;
        bus.req = 4'b0001;
        wait_start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_start", 32'(bus.conv_start), 0);
        check("t4_ack", 32'(bus.ack), 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.operand[23:16] = 8'h5A;
        bus.req = 4'b0100;
        wait_ack(a);
        bus.req = '0;
        check("t4_ack2", 32'(a), 32'h4);
        check("t4_gid", 32'(bus.grant_id), 2);

        // Requester 2 holds req one cycle past its ack: no re-grant
        repeat (2) @(negedge clk);
        base = ack_cnt[2];
        bus.operand[23:16] = 8'h21;
        bus.req = 4'b0100;
        wait_ack(a);
        repeat (2) @(negedge clk);
        bus.req = '0;
        repeat (20) @(negedge clk);
        check("t5_ackcnt", ack_cnt[2] - base, 1);
        check("t5_idle", 32'(bus.busy), 0);

        // Randomized traffic, each client drops req on its ack
        for (int i = 0; i < 4; i++) cool[i] = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) begin
                    bus.req[i] = 1'b0;
                    cool[i] = 2 + int'($urandom_range(0, 2));
                end else if (!bus.req[i]) begin
                    if (cool[i] > 0) cool[i]--;
                    else if (t < 1300 && $urandom_range(0, 2) == 0) begin
                        bus.operand[i*8 +: 8] = 8'($urandom_range(0, 127));
                        bus.req[i] = 1'b1;
                    end
                end
            end
        end
        idle = 1'b0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
            if (bus.req == 0 && !bus.busy) idle = 1'b1;
        end
        check("rnd_drain", 32'(idle), 1);

`ifdef CSD_ARB_TIMEOUT_EN
        // Converter never answers: watchdog ack 16 cycles after start rises
        repeat (2) @(negedge clk);
        hang = 1'b1;
        bus.operand[7:0] = 8'h12;
        bus.req = 4'b0001;
        wait_start();
        n = 0;
        for (int i = 0; i < 100 && bus.ack == 0; i++) begin
            @(negedge clk);
            n++;
        end
        bus.req = '0;
        check("tmo_latency", n, TMO);
        check("tmo_err", 32'(bus.res_err), 1);
        check("tmo_res", {bus.res_pos, bus.res_neg}, 0);
        @(negedge clk);
        check("tmo_idle", 32'(bus.busy), 0);
        poke_done = 1'b1;
        @(negedge clk);
        poke_done = 1'b0;
        repeat (2) @(negedge clk);
        check("late_done_busy", 32'(bus.busy), 0);
        check("late_done_ack", 32'(bus.ack), 0);
        hang = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
